// File: rtl/lfsr_fibonacci_checker.sv
// Self-synchronising checker for a Fibonacci LFSR bitstream: seeds from the line, predicts, counts errors.
// Optional stuck-low detection on the seed window is enabled with `define LFSR_CHECK_ZERO_DETECT_EN.
`timescale 1ns/1ps

module lfsr_fibonacci_checker #(
    parameter int LOSS_THRESHOLD = 8,
    parameter int ERR_CNT_WIDTH  = 16,
    parameter int BIT_CNT_WIDTH  = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               lfsr_length,
    input  logic                     lfsr_n_taps,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     cnt_clear,
    output logic                     cfg_valid,
    output logic                     locked,
    output logic                     err_pulse,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [BIT_CNT_WIDTH-1:0] bit_count,
    output logic                     stuck_zero
);

    localparam logic [1:0] ST_INVALID = 2'd0;
    localparam logic [1:0] ST_SEED    = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [3:0]               LOSS_TH  = 4'(LOSS_THRESHOLD);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = {ERR_CNT_WIDTH{1'b1}};
    localparam logic [BIT_CNT_WIDTH-1:0] BIT_MAX  = {BIT_CNT_WIDTH{1'b1}};

    logic [1:0]               state_reg, state_next;
    logic [15:0]              win_reg, win_next;
    logic [3:0]               seed_cnt_reg, seed_cnt_next;
    logic [3:0]               consec_reg, consec_next;
    logic [4:0]               cfg_q_reg, cfg_q_next;
    logic [ERR_CNT_WIDTH-1:0] err_count_reg, err_count_next;
    logic [BIT_CNT_WIDTH-1:0] bit_count_reg, bit_count_next;
    logic                     locked_reg;
    logic                     err_pulse_reg;
    logic                     cfg_valid_reg;

    logic [4:0]  cfg_in;
    logic        cfg_change;
    logic [15:0] mask;
    logic        mask_valid;
    logic [15:0] win_shift;
    logic        expected_bit;
    logic        mismatch;
    logic        compare;

    assign cfg_in       = {lfsr_length, lfsr_n_taps};
    assign cfg_change   = (cfg_in != cfg_q_reg);
    assign win_shift    = {win_reg[14:0], bit_in};
    assign expected_bit = ^(win_reg & mask);
    assign mask_valid   = (mask != 16'h0000);

    // Looked up from the live inputs; they equal cfg_q whenever the datapath uses the mask.
    always_comb begin
        mask = 16'h0000;
        case ({lfsr_n_taps, lfsr_length})
            5'h02:   mask = 16'h0003;
            5'h03:   mask = 16'h0006;
            5'h04:   mask = 16'h000C;
            5'h05:   mask = 16'h0014;
            5'h06:   mask = 16'h0030;
            5'h07:   mask = 16'h0060;
            5'h09:   mask = 16'h0110;
            5'h0A:   mask = 16'h0240;
            5'h0B:   mask = 16'h0500;
            5'h0F:   mask = 16'h6000;
            5'h15:   mask = 16'h001E;
            5'h16:   mask = 16'h0036;
            5'h17:   mask = 16'h0078;
            5'h18:   mask = 16'h00B8;
            5'h19:   mask = 16'h01B0;
            5'h1A:   mask = 16'h0360;
            5'h1B:   mask = 16'h0740;
            5'h1C:   mask = 16'h0CA0;
            5'h1D:   mask = 16'h1B00;
            5'h1E:   mask = 16'h3500;
            5'h1F:   mask = 16'h7400;
            default: mask = 16'h0000;
        endcase
    end

`ifdef LFSR_CHECK_ZERO_DETECT_EN
    logic [15:0] len_mask;
    logic        seed_zero;
    logic        stuck_zero_reg, stuck_zero_next;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_len_mask
            assign len_mask[gi] = (5'(gi) < {1'b0, cfg_q_reg[4:1]});
        end
    endgenerate
`endif

    always_comb begin
        state_next    = state_reg;
        win_next      = win_reg;
        seed_cnt_next = seed_cnt_reg;
        consec_next   = consec_reg;
        cfg_q_next    = cfg_q_reg;
        mismatch      = 1'b0;
        compare       = 1'b0;
`ifdef LFSR_CHECK_ZERO_DETECT_EN
        seed_zero     = 1'b0;
`endif
        if (cfg_change) begin
            // A new configuration restarts acquisition; the bit on this cycle is dropped.
            cfg_q_next    = cfg_in;
            win_next      = 16'h0000;
            seed_cnt_next = 4'd0;
            consec_next   = 4'd0;
            state_next    = ST_INVALID;
        end else begin
            case (state_reg)
                ST_INVALID: begin
                    if (mask_valid) begin
                        state_next = ST_SEED;
                    end
                end
                ST_SEED: begin
                    if (bit_valid) begin
                        win_next = win_shift;
                        if (seed_cnt_reg + 4'd1 == lfsr_length) begin
                            seed_cnt_next = 4'd0;
`ifdef LFSR_CHECK_ZERO_DETECT_EN
                            if ((win_shift & len_mask) == 16'h0000) begin
                                seed_zero  = 1'b1;
                                state_next = ST_SEED;
                            end else begin
                                state_next = ST_LOCKED;
                            end
`else
                            state_next = ST_LOCKED;
`endif
                        end else begin
                            seed_cnt_next = seed_cnt_reg + 4'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bit_valid) begin
                        // The received bit enters the window so one line error costs 1 + taps mismatches.
                        win_next = win_shift;
                        compare  = 1'b1;
                        if (bit_in != expected_bit) begin
                            mismatch = 1'b1;
                            if (consec_reg + 4'd1 == LOSS_TH) begin
                                consec_next = 4'd0;
                                state_next  = ST_SEED;
                            end else begin
                                consec_next = consec_reg + 4'd1;
                            end
                        end else begin
                            consec_next = 4'd0;
                        end
                    end
                end
                default: state_next = ST_INVALID;
            endcase
        end
    end

    always_comb begin
        err_count_next = err_count_reg;
        bit_count_next = bit_count_reg;
        if (cnt_clear) begin
            err_count_next = '0;
            bit_count_next = '0;
        end else begin
            if (mismatch && (err_count_reg != ERR_MAX)) begin
                err_count_next = err_count_reg + ERR_CNT_WIDTH'(1);
            end
            if (compare && (bit_count_reg != BIT_MAX)) begin
                bit_count_next = bit_count_reg + BIT_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_INVALID;
            win_reg       <= 16'h0000;
            seed_cnt_reg  <= 4'd0;
            consec_reg    <= 4'd0;
            cfg_q_reg     <= 5'd0;
            err_count_reg <= '0;
            bit_count_reg <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
            cfg_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            win_reg       <= win_next;
            seed_cnt_reg  <= seed_cnt_next;
            consec_reg    <= consec_next;
            cfg_q_reg     <= cfg_q_next;
            err_count_reg <= err_count_next;
            bit_count_reg <= bit_count_next;
            locked_reg    <= (state_next == ST_LOCKED);
            err_pulse_reg <= mismatch;
            cfg_valid_reg <= mask_valid;
        end
    end

`ifdef LFSR_CHECK_ZERO_DETECT_EN
    always_comb begin
        stuck_zero_next = stuck_zero_reg;
        if (cfg_change || cnt_clear) begin
            stuck_zero_next = 1'b0;
        end else if (seed_zero) begin
            stuck_zero_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stuck_zero_reg <= 1'b0;
        end else begin
            stuck_zero_reg <= stuck_zero_next;
        end
    end

    assign stuck_zero = stuck_zero_reg;
`else
    assign stuck_zero = 1'b0;
`endif

    assign cfg_valid = cfg_valid_reg;
    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;
    assign bit_count = bit_count_reg;

endmodule

// File: tb/tb_lfsr_fibonacci_checker.sv
// Directed bench for lfsr_fibonacci_checker: lock, error injection, invalid config, loss/relock, clear, reset, zero stream.
`timescale 1ns/1ps

module tb_lfsr_fibonacci_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  lfsr_length = 4'd0;
    logic        lfsr_n_taps = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        cnt_clear = 1'b0;
    logic        cfg_valid;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [23:0] bit_count;
    logic        stuck_zero;

    int pass_cnt = 0;
    int total_cnt = 0;
    int pulse_cnt = 0;
    logic [15:0] g;
    logic [15:0] gmask;

    lfsr_fibonacci_checker #(
        .LOSS_THRESHOLD(8),
        .ERR_CNT_WIDTH (16),
        .BIT_CNT_WIDTH (24)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lfsr_length(lfsr_length),
        .lfsr_n_taps(lfsr_n_taps),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .cnt_clear  (cnt_clear),
        .cfg_valid  (cfg_valid),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .bit_count  (bit_count),
        .stuck_zero (stuck_zero)
    );

    always #5 clk = ~clk;

    // Reference Fibonacci generator: output = parity of tapped history, then shifted in.
    task automatic gen_bit(output logic b);
        b = ^(g & gmask);
        g = {g[14:0], b};
    endtask

    task automatic send_bit(input logic b, input logic clr);
        @(negedge clk);
        bit_in    = b;
        bit_valid = 1'b1;
        cnt_clear = clr;
        @(posedge clk);
        #1;
        if (err_pulse) pulse_cnt++;
        $display("bit=%0b clr=%0b locked=%0b err_pulse=%0b err_count=%0d bit_count=%0d",
                 b, clr, locked, err_pulse, err_count, bit_count);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bit_valid = 1'b0;
        cnt_clear = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [3:0] len, input logic taps);
        @(negedge clk);
        rst         = 1'b1;
        lfsr_length = len;
        lfsr_n_taps = taps;
        bit_valid   = 1'b0;
        cnt_clear   = 1'b0;
        bit_in      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pulse_cnt = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        lfsr_length = 4'd4;
        lfsr_n_taps = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({locked, err_pulse, cfg_valid, stuck_zero} !== 4'b0000)
            $display("FAIL reset_flags got=%b want=0000", {locked, err_pulse, cfg_valid, stuck_zero});
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 16'd0 || bit_count !== 24'd0)
            $display("FAIL reset_counts got err=%0d bits=%0d want 0/0", err_count, bit_count);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (cfg_valid !== 1'b1) $display("FAIL reset_cfg_valid got=%b want=1", cfg_valid);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_lock_len4(input int flip_at);
        logic b;
        apply_reset(4'd4, 1'b0);
        g = 16'd1;
        gmask = 16'h000C;
        for (int i = 1; i <= 100; i++) begin
            gen_bit(b);
            send_bit((i == flip_at) ? ~b : b, 1'b0);
            if (i == 3) begin
                total_cnt++;
                if (locked !== 1'b0) $display("FAIL lock_early got=%b want=0", locked);
                else pass_cnt++;
            end
            if (i == 4) begin
                total_cnt++;
                if (locked !== 1'b1) $display("FAIL lock_at_4 got=%b want=1", locked);
                else pass_cnt++;
            end
        end
        idle(1);
        total_cnt++;
        if (err_count !== ((flip_at > 0) ? 16'd3 : 16'd0))
            $display("FAIL len4_err_count flip=%0d got=%0d", flip_at, err_count);
        else pass_cnt++;
        total_cnt++;
        if (pulse_cnt !== ((flip_at > 0) ? 3 : 0))
            $display("FAIL len4_pulses flip=%0d got=%0d", flip_at, pulse_cnt);
        else pass_cnt++;
        total_cnt++;
        if (bit_count !== 24'd96) $display("FAIL len4_bit_count got=%0d want=96", bit_count);
        else pass_cnt++;
        total_cnt++;
        if (locked !== 1'b1) $display("FAIL len4_still_locked got=%b want=1", locked);
        else pass_cnt++;
        $display("test_lock_len4 flip_at=%0d done", flip_at);
    endtask

    task automatic test_invalid_cfg();
        logic b;
        apply_reset(4'd8, 1'b0);
        total_cnt++;
        if (cfg_valid !== 1'b0) $display("FAIL inv_cfg_valid got=%b want=0", cfg_valid);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) send_bit(i[0], 1'b0);
        idle(1);
        total_cnt++;
        if (locked !== 1'b0 || err_count !== 16'd0 || bit_count !== 24'd0)
            $display("FAIL inv_idle got locked=%b err=%0d bits=%0d want 0/0/0", locked, err_count, bit_count);
        else pass_cnt++;
        @(negedge clk);
        lfsr_n_taps = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (cfg_valid !== 1'b1) $display("FAIL len8_cfg_valid got=%b want=1", cfg_valid);
        else pass_cnt++;
        g = 16'd1;
        gmask = 16'h00B8;
        for (int i = 1; i <= 38; i++) begin
            gen_bit(b);
            send_bit(b, 1'b0);
            if (i == 7) begin
                total_cnt++;
                if (locked !== 1'b0) $display("FAIL len8_early got=%b want=0", locked);
                else pass_cnt++;
            end
            if (i == 8) begin
                total_cnt++;
                if (locked !== 1'b1) $display("FAIL len8_lock got=%b want=1", locked);
                else pass_cnt++;
            end
        end
        idle(1);
        total_cnt++;
        if (err_count !== 16'd0 || bit_count !== 24'd30)
            $display("FAIL len8_counts got err=%0d bits=%0d want 0/30", err_count, bit_count);
        else pass_cnt++;
        $display("test_invalid_cfg done");
    endtask

    task automatic test_loss_relock();
        logic b;
        int n_inv;
        apply_reset(4'd7, 1'b1);
        g = 16'd1;
        gmask = 16'h0078;
        for (int i = 0; i < 17; i++) begin
            gen_bit(b);
            send_bit(b, 1'b0);
        end
        total_cnt++;
        if (locked !== 1'b1 || err_count !== 16'd0)
            $display("FAIL len7_lock got locked=%b err=%0d want 1/0", locked, err_count);
        else pass_cnt++;
        // Taps 3..6: inverted bits match at the 5th and 7th, then 8 straight mismatches.
        n_inv = 0;
        do begin
            gen_bit(b);
            send_bit(~b, 1'b0);
            n_inv++;
        end while (locked && n_inv < 40);
        total_cnt++;
        if (n_inv !== 15 || locked !== 1'b0)
            $display("FAIL loss_point got bits=%0d locked=%b want 15/0", n_inv, locked);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 16'd13) $display("FAIL loss_err_count got=%0d want=13", err_count);
        else pass_cnt++;
        for (int i = 1; i <= 27; i++) begin
            gen_bit(b);
            send_bit(b, 1'b0);
            if (i == 6) begin
                total_cnt++;
                if (locked !== 1'b0) $display("FAIL relock_early got=%b want=0", locked);
                else pass_cnt++;
            end
            if (i == 7) begin
                total_cnt++;
                if (locked !== 1'b1) $display("FAIL relock got=%b want=1", locked);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (err_count !== 16'd13 || locked !== 1'b1)
            $display("FAIL relock_clean got err=%0d locked=%b want 13/1", err_count, locked);
        else pass_cnt++;
        $display("test_loss_relock done");
    endtask

    task automatic test_clear_and_reset();
        logic b;
        apply_reset(4'd4, 1'b0);
        g = 16'd1;
        gmask = 16'h000C;
        for (int i = 1; i <= 60; i++) begin
            gen_bit(b);
            send_bit((i == 30 || i == 40) ? ~b : b, i == 44);
            if (i == 43) begin
                total_cnt++;
                if (err_count !== 16'd5) $display("FAIL pre_clear_err got=%0d want=5", err_count);
                else pass_cnt++;
            end
            if (i == 44) begin
                total_cnt++;
                if (err_count !== 16'd0 || err_pulse !== 1'b1)
                    $display("FAIL clear_priority got err=%0d pulse=%b want 0/1", err_count, err_pulse);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (err_count !== 16'd0 || bit_count !== 24'd16 || locked !== 1'b1)
            $display("FAIL post_clear got err=%0d bits=%0d locked=%b want 0/16/1", err_count, bit_count, locked);
        else pass_cnt++;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({locked, err_pulse, cfg_valid, stuck_zero} !== 4'b0000 || bit_count !== 24'd0)
            $display("FAIL async_reset got flags=%b bits=%0d want 0000/0",
                     {locked, err_pulse, cfg_valid, stuck_zero}, bit_count);
        else pass_cnt++;
        $display("test_clear_and_reset done");
    endtask

    task automatic test_zero_stream();
        logic any_locked;
        apply_reset(4'd5, 1'b0);
        any_locked = 1'b0;
        for (int i = 0; i < 30; i++) begin
            send_bit(1'b0, 1'b0);
            if (locked) any_locked = 1'b1;
        end
`ifdef LFSR_CHECK_ZERO_DETECT_EN
        total_cnt++;
        if (any_locked !== 1'b0) $display("FAIL zero_never_lock got=%b want=0", any_locked);
        else pass_cnt++;
        total_cnt++;
        if (stuck_zero !== 1'b1) $display("FAIL zero_stuck got=%b want=1", stuck_zero);
        else pass_cnt++;
`else
        total_cnt++;
        if (locked !== 1'b1 || any_locked !== 1'b1)
            $display("FAIL zero_lock got=%b want=1", locked);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== 16'd0 || bit_count !== 24'd25 || stuck_zero !== 1'b0)
            $display("FAIL zero_counts got err=%0d bits=%0d stuck=%b want 0/25/0", err_count, bit_count, stuck_zero);
        else pass_cnt++;
`endif
        $display("test_zero_stream done");
    endtask

    initial begin
        test_reset();
        test_lock_len4(0);
        test_lock_len4(50);
        test_invalid_cfg();
        test_loss_relock();
        test_clear_and_reset();
        test_zero_stream();
        idle(2);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
